// File: rtl/sdram_port_arbiter.sv
// Round-robin share of one sdram_dualport client port among three requesters; a tag FIFO
// steers read data back to its issuer. Define SDRAM_ARB_AGE_EN to add wait-time aging.
module sdram_port_arbiter #(
   parameter int AW      = 23,
   parameter int DW      = 16,
   parameter int MAX_RD  = 4,
   parameter int AGE_MAX = 63
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              rq_req,
   input  logic [2:0]              rq_we,
   input  logic [3*AW-1:0]         rq_addr,
   input  logic [3*DW-1:0]         rq_wdata,
   output logic [2:0]              rq_ack,
   output logic [2:0]              rq_valid,
   output logic [DW-1:0]           rq_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [AW-1:0]           mem_addr,
   output logic [DW-1:0]           mem_wdata,
   input  logic                    mem_ack,
   input  logic                    mem_valid,
   input  logic [DW-1:0]           mem_rdata,
   output logic [$clog2(MAX_RD):0] rd_pending,
   output logic                    orphan_err
);
   localparam int PW = $clog2(MAX_RD);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(MAX_RD);
   localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
   state_t state_q, state_d;

   logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d, rq_rdata_q, rq_rdata_d;
   logic [1:0]      gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
   logic [2:0]      rq_ack_q, rq_ack_d, rq_valid_q, rq_valid_d;
   logic            orphan_q, orphan_d;
   logic [1:0]      tag_q [MAX_RD];
   logic [1:0]      tag_d [MAX_RD];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]     cnt_q, cnt_d;

   logic [2:0]      eligible;
   logic            fifo_full, found, grant_now, push, pop;
   logic [1:0]      sel, cand;

`ifdef SDRAM_ARB_AGE_EN
   localparam logic [5:0] AGE_LIM = 6'(AGE_MAX);
   logic [5:0] age_q [3];
   logic [5:0] age_d [3];
`endif

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      logic [2:0] r;
      r = (v >= 3'd3) ? v - 3'd3 : v;
      return r[1:0];
   endfunction

   // Writes never touch the tag FIFO, so a full FIFO only holds back reads.
   assign fifo_full = (cnt_q == CNT_FULL);
   assign eligible  = rq_req & (rq_we | {3{~fifo_full}});

   always_comb begin : grant_select
      found = 1'b0;
      sel   = 2'd0;
      cand  = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         cand = wrap3({1'b0, rr_ptr_q} + 3'(k));
         if (!found && eligible[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
`ifdef SDRAM_ARB_AGE_EN
      for (int i = 2; i >= 0; i--) begin
         if (eligible[i] && age_q[i] >= AGE_LIM) begin
            found = 1'b1;
            sel   = 2'(i);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin : state_reg
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = ISSUE;
         ISSUE:   if (mem_ack) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : fsm_outputs
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      gnt_d       = gnt_q;
      rr_ptr_d    = rr_ptr_q;
      rq_ack_d    = 3'b000;
      grant_now   = 1'b0;
      push        = 1'b0;
      case (state_q)
         IDLE: if (found) begin
            grant_now   = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = rq_we[sel];
            mem_addr_d  = rq_addr[sel*AW +: AW];
            mem_wdata_d = rq_wdata[sel*DW +: DW];
            gnt_d       = sel;
            rr_ptr_d    = sel;
         end
         ISSUE: if (mem_ack) begin
            mem_req_d = 1'b0;
            rq_ack_d  = 3'b001 << gnt_q;
            push      = ~mem_we_q;
         end
         default: ;
      endcase
   end

   // Read return runs regardless of FSM state; data with no tag is dropped and flagged.
   always_comb begin : read_return
      pop        = mem_valid & (cnt_q != '0);
      rq_valid_d = pop ? (3'b001 << tag_q[rd_ptr_q]) : 3'b000;
      rq_rdata_d = pop ? mem_rdata : rq_rdata_q;
      orphan_d   = orphan_q | (mem_valid & (cnt_q == '0));
      tag_d      = tag_q;
      if (push) tag_d[wr_ptr_q] = gnt_q;
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin : datapath_reg
      if (reset) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         gnt_q       <= 2'd0;
         rr_ptr_q    <= 2'd0;
         rq_ack_q    <= 3'b000;
         rq_valid_q  <= 3'b000;
         rq_rdata_q  <= '0;
         orphan_q    <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < MAX_RD; i++) tag_q[i] <= 2'd0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         gnt_q       <= gnt_d;
         rr_ptr_q    <= rr_ptr_d;
         rq_ack_q    <= rq_ack_d;
         rq_valid_q  <= rq_valid_d;
         rq_rdata_q  <= rq_rdata_d;
         orphan_q    <= orphan_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         tag_q       <= tag_d;
      end
   end

`ifdef SDRAM_ARB_AGE_EN
   // A requester ages while it waits, not while its own command is being issued.
   always_comb begin : age_next
      for (int i = 0; i < 3; i++) begin
         age_d[i] = age_q[i];
         if (grant_now && sel == 2'(i))
            age_d[i] = 6'd0;
         else if (rq_req[i] && !(state_q != IDLE && gnt_q == 2'(i)) && age_q[i] != 6'h3f)
            age_d[i] = age_q[i] + 6'd1;
      end
   end

   always_ff @(posedge clk) begin : age_reg
      if (reset) for (int i = 0; i < 3; i++) age_q[i] <= 6'd0;
      else       age_q <= age_d;
   end
`endif

   assign rq_ack     = rq_ack_q;
   assign rq_valid   = rq_valid_q;
   assign rq_rdata   = rq_rdata_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign rd_pending = cnt_q;
   assign orphan_err = orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: grant order, read-tag routing, FIFO limits, reset.
module tb_sdram_port_arbiter;
  localparam int AW = 23;
  localparam int DW = 16;
  localparam int MAX_RD = 4;
  localparam int AGE_MAX = 63;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      rq_req, rq_we, rq_ack, rq_valid;
  logic [3*AW-1:0] rq_addr;
  logic [3*DW-1:0] rq_wdata;
  logic [DW-1:0]   rq_rdata, mem_wdata, mem_rdata;
  logic            mem_req, mem_we, mem_ack, mem_valid, orphan_err;
  logic [AW-1:0]   mem_addr;
  logic [2:0]      rd_pending;

  sdram_port_arbiter #(.AW(AW), .DW(DW), .MAX_RD(MAX_RD), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .reset(reset),
    .rq_req(rq_req), .rq_we(rq_we), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .rq_ack(rq_ack), .rq_valid(rq_valid), .rq_rdata(rq_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .rd_pending(rd_pending), .orphan_err(orphan_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int total_acks = 0;
  logic [17:0]   exp_q[$];   // {requester, data} in issue order
  logic [AW-1:0] ctl_q[$];   // addresses accepted by the controller model
  int            gnt_log[$];
  logic [2:0]    hold_req;
  logic          auto_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hBFEF;
  endfunction

  // One cycle: monitor outputs #1 after the edge, then the controller model responds.
  task automatic step();
    logic [17:0] e;
    @(posedge clk);
    #1;
    if (rq_ack != 3'b000) begin
      check("ack_onehot", $countones(rq_ack), 1);
      for (int i = 0; i < 3; i++) begin
        if (rq_ack[i]) begin
          total_acks++;
          gnt_log.push_back(i);
          if (!rq_we[i]) exp_q.push_back({2'(i), model_data(rq_addr[i*AW +: AW])});
          if (!hold_req[i]) rq_req[i] = 1'b0;
        end
      end
    end
    if (rq_valid != 3'b000) begin
      if (exp_q.size() == 0) check("valid_unexpected", rq_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("valid_port", rq_valid, 3'b001 << e[17:16]);
        check("valid_data", rq_rdata, e[15:0]);
      end
    end
    mem_valid = 1'b0;
    mem_ack = auto_ack & mem_req;
    if (mem_ack && !mem_we) ctl_q.push_back(mem_addr);
  endtask

  task automatic drive_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq_req[i] = 1'b1;
    rq_we[i] = we;
    rq_addr[i*AW +: AW] = a;
    rq_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_acks(input int target, input int budget, input string tag);
    int c = 0;
    while (total_acks < target && c < budget) begin
      step();
      c++;
    end
    if (total_acks < target) check({tag, "_timeout"}, total_acks, target);
  endtask

  task automatic ret_read();
    logic [AW-1:0] a;
    a = (ctl_q.size() != 0) ? ctl_q.pop_front() : '0;
    mem_valid = 1'b1;
    mem_rdata = model_data(a);
    step();
  endtask

  task automatic drain(input string tag);
    int c = 0;
    hold_req = 3'b000;
    while ((rq_req != 3'b000 || mem_req) && c < 40) begin
      step();
      c++;
    end
    check({tag, "_drain"}, {rq_req, mem_req}, 0);
    step();
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rq_req = '0; rq_we = '0; hold_req = '0; auto_ack = 1'b0;
    mem_ack = 1'b0; mem_valid = 1'b0;
    step();
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_rq_ack", rq_ack, 0);
    check("rst_rq_valid", rq_valid, 0);
    check("rst_rd_pending", rd_pending, 0);
    check("rst_orphan", orphan_err, 0);
    reset = 1'b0;
    exp_q.delete();
    ctl_q.delete();
    gnt_log.delete();
  endtask

  initial begin
    int c;
    int order[6];
    order = '{1, 2, 0, 1, 2, 0};
    rq_addr = '0; rq_wdata = '0; mem_rdata = '0;
    do_reset();

    // 1: single read, latency and return
    drive_req(0, 1'b0, 23'h100, 16'h0);
    step();
    check("s1_mem_req_lat", mem_req, 1);
    check("s1_mem_addr", mem_addr, 23'h100);
    check("s1_mem_we", mem_we, 0);
    step();
    check("s1_mem_req_hold", mem_req, 1);
    auto_ack = 1'b1;
    step();
    step();
    check("s1_rq_ack", rq_ack, 3'b001);
    step();
    check("s1_ack_pulse", rq_ack, 0);
    check("s1_pending", rd_pending, 1);
    ret_read();
    check("s1_valid", rq_valid, 3'b001);
    check("s1_rdata", rq_rdata, 16'hBEEF);
    check("s1_pending0", rd_pending, 0);

    // 2: all requesters held, round-robin order
    do_reset();
    hold_req = 3'b111;
    for (int i = 0; i < 3; i++) drive_req(i, 1'b1, 23'h10 + 23'(i), 16'(i) + 16'hA0);
    auto_ack = 1'b1;
    wait_acks(total_acks + 6, 60, "s2");
    for (int k = 0; k < 6; k++) check("s2_order", (k < gnt_log.size()) ? gnt_log[k] : 7, order[k]);
    drain("s2");

    // 3: reads from 0,1,2 returned in order
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(i, 1'b0, 23'h200 + 23'(i), 16'h0);
      wait_acks(total_acks + 1, 20, "s3_issue");
    end
    check("s3_pending3", rd_pending, 3);
    for (int i = 0; i < 3; i++) begin
      ret_read();
      check("s3_valid_seq", rq_valid, 3'b001 << i);
      check("s3_pending", rd_pending, 32'(2 - i));
    end

    // 4: full FIFO blocks reads, not writes; simultaneous push and pop
    do_reset();
    auto_ack = 1'b1;
    for (int k = 0; k < MAX_RD; k++) begin
      drive_req(0, 1'b0, 23'h300 + 23'(k), 16'h0);
      wait_acks(total_acks + 1, 20, "s4_fill");
    end
    check("s4_full", rd_pending, MAX_RD);
    drive_req(1, 1'b0, 23'h310, 16'h0);
    drive_req(2, 1'b1, 23'h320, 16'h1234);
    wait_acks(total_acks + 1, 20, "s4_write");
    check("s4_write_granted", (gnt_log.size() != 0) ? gnt_log[gnt_log.size()-1] : 7, 2);
    check("s4_wdata", mem_wdata, 16'h1234);
    for (int k = 0; k < 5; k++) step();
    check("s4_read_blocked", {rq_req[1], mem_req}, 2'b10);
    check("s4_still_full", rd_pending, MAX_RD);
    auto_ack = 1'b0;
    ret_read();
    check("s4_pending3", rd_pending, 3);
    c = 0;
    while (!mem_req && c < 10) begin step(); c++; end
    check("s4_read_issued", mem_req, 1);
    check("s4_read_addr", mem_addr, 23'h310);
    mem_rdata = model_data((ctl_q.size() != 0) ? ctl_q.pop_front() : '0);
    ctl_q.push_back(mem_addr);
    mem_valid = 1'b1;
    mem_ack = 1'b1;
    step();
    check("s4_push_pop", rd_pending, 3);
    step();
    for (int k = 0; k < 3; k++) begin
      ret_read();
      check("s4_drain", rd_pending, 32'(2 - k));
    end

    // 5: orphan data, reset during ISSUE, reads forgotten by reset
    do_reset();
    mem_valid = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    check("s5_no_valid", rq_valid, 0);
    check("s5_orphan", orphan_err, 1);
    step();
    check("s5_orphan_sticky", orphan_err, 1);
    drive_req(0, 1'b1, 23'h400, 16'h55);
    step();
    check("s5_issue", mem_req, 1);
    reset = 1'b1;
    step();
    check("s5_rst_mem_req", mem_req, 0);
    check("s5_rst_orphan", orphan_err, 0);
    reset = 1'b0;
    rq_req = 3'b000;
    step();
    check("s5_rst_no_ack", rq_ack, 0);
    auto_ack = 1'b1;
    drive_req(0, 1'b0, 23'h500, 16'h0);
    wait_acks(total_acks + 1, 20, "s5_read");
    check("s5_inflight", rd_pending, 1);
    auto_ack = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    check("s5_forgotten", rd_pending, 0);
    ret_read();
    check("s5_late_valid", rq_valid, 0);
    check("s5_late_orphan", orphan_err, 1);

    // 6: requester 0 under continuous competition is served
    do_reset();
    hold_req = 3'b111;
    for (int i = 0; i < 3; i++) drive_req(i, 1'b1, 23'h600 + 23'(i), 16'h0);
    auto_ack = 1'b1;
    c = 0;
    while (!(0 inside {gnt_log}) && c < 3 * AGE_MAX + 20) begin step(); c++; end
    check("s6_req0_served", (0 inside {gnt_log}) ? 1 : 0, 1);
    wait_acks(total_acks + 3, 20, "s6");
    for (int k = 0; k < 3; k++) check("s6_order", (k < gnt_log.size()) ? gnt_log[k] : 7, order[k]);
    drain("s6");

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
